mio_bus_arbiter: RTL

Two-master arbiter and transaction sequencer placed in front of the MIO bus decoder. It shares the single MIO bus (address, write data, write strobe, read data) between the CPU (master 0) and a DMA/display fetch engine (master 1). It uses round-robin arbitration and a fixed per-transaction FSM, and inserts read wait states for the synchronous block RAM behind the bus. It also blocks master-1 writes into the GPIO regions.

---
 rtl/mio_bus_arbiter_pkg.sv | 25 ++
 rtl/mio_bus_arbiter_if.sv | 56 +++++
 rtl/mio_bus_arbiter_rr_arb2.sv | 21 ++
 rtl/mio_bus_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mio_bus_arbiter_pkg.sv
// Shared types and constants for the MIO bus arbiter and related blocks.
package mio_pkg;

  // Default bus geometry.
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;

  // Top address nibbles of the GPIO regions that master 1 may not write.
  localparam logic [3:0] GpioRegionE = 4'hE;
  localparam logic [3:0] GpioRegionF = 4'hF;

  // Per-transaction sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StWait = 2'd2,
    StAck  = 2'd3
  } mio_state_e;

  // True when the top address nibble falls in a GPIO region.
  function automatic logic is_gpio_region(input logic [3:0] nib);
    return (nib == GpioRegionE) || (nib == GpioRegionF);
  endfunction

endpackage

// File: rtl/mio_bus_arbiter_if.sv
// Request/response handshake of both masters plus the shared MIO bus.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mio_bus_arbiter_if #(
  parameter int unsigned ADDR_W = mio_pkg::DefAddrW,
  parameter int unsigned DATA_W = mio_pkg::DefDataW
) ();

  // Master 0 (CPU)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  // Master 1 (DMA / display fetch)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  // Shared bus toward the decoder
  logic              mem_w;
  logic [ADDR_W-1:0] addr_bus;
  logic [DATA_W-1:0] Cpu_data2bus;
  logic [DATA_W-1:0] Cpu_data4bus;

  // Status
  logic              bus_busy;
  logic              grant;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_w, addr_bus, Cpu_data2bus,
    input  Cpu_data4bus,
    output bus_busy, grant
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_w, addr_bus, Cpu_data2bus,
    output Cpu_data4bus,
    input  bus_busy, grant
  );

endinterface

// File: rtl/mio_bus_arbiter_rr_arb2.sv
// Two-requester round-robin pick: on a tie the requester that did not win
// last time is chosen. Purely combinational so other shared blocks can reuse it.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_grant
);

  // Winner selection: lone requester wins, tie goes to the non-last winner.
  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_grant = ~i_last_grant;
    end else begin
      o_grant = i_req1;
    end
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter and transaction sequencer in front of the MIO bus decoder.
// One transaction at a time: IDLE -> ADDR -> (WAIT x RD_WAIT for reads) -> ACK.
// Master-1 writes into the GPIO regions are suppressed and flagged with m1_err.
module mio_bus_arbiter
  import mio_pkg::*;
#(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW
) (
  input logic              clk,
  input logic              rst,
  mio_bus_arbiter_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(RD_WAIT + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(RD_WAIT);

  mio_state_e r_state;
  mio_state_e w_state_next;

  logic              r_owner;
  logic              r_last_grant;
  logic              r_we;
  logic              r_blocked;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_arb_valid;
  logic              w_arb_grant;
  logic              w_req_we;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;
  logic              w_req_blocked;
  logic              w_start;
  logic              w_cnt_last;

  rr_arb2 u_rr_arb2 (
    .i_req0       (bus.m0_req),
    .i_req1       (bus.m1_req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_arb_valid),
    .o_grant      (w_arb_grant)
  );

  // Request fields of the current arbitration winner.
  always_comb begin
    w_req_we      = w_arb_grant ? bus.m1_we    : bus.m0_we;
    w_req_addr    = w_arb_grant ? bus.m1_addr  : bus.m0_addr;
    w_req_wdata   = w_arb_grant ? bus.m1_wdata : bus.m0_wdata;
    w_req_blocked = w_arb_grant & w_req_we & is_gpio_region(w_req_addr[ADDR_W-1 -: 4]);
    w_start       = (r_state == StIdle) & w_arb_valid;
    w_cnt_last    = (r_cnt == CntW'(1));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; ACK always returns to IDLE so a stale req is not resampled early.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_arb_valid) w_state_next = StAddr;
      StAddr:  w_state_next = r_we ? StAck : StWait;
      StWait:  if (w_cnt_last) w_state_next = StAck;
      StAck:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Latch winner and request fields when a transaction starts; later master changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;  // CPU wins the first tie after reset
      r_we         <= 1'b0;
      r_blocked    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_start) begin
      r_owner      <= w_arb_grant;
      r_last_grant <= w_arb_grant;
      r_we         <= w_req_we;
      r_blocked    <= w_req_blocked;
      r_addr       <= w_req_addr;
      r_wdata      <= w_req_wdata;
    end
  end

  // Read wait-state counter, loaded on ADDR->WAIT and counting down to the capture cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((r_state == StAddr) && !r_we) begin
      r_cnt <= CntLoad;
    end else if ((r_state == StWait) && !w_cnt_last) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  // Capture read data for the owning master on the last WAIT cycle; held until its next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if ((r_state == StWait) && w_cnt_last) begin
      if (r_owner) begin
        r_rdata1 <= bus.Cpu_data4bus;
      end else begin
        r_rdata0 <= bus.Cpu_data4bus;
      end
    end
  end

  // FSM outputs: strobe only in ADDR, acks only in ACK, bus values held from the latches.
  always_comb begin
    bus.mem_w        = (r_state == StAddr) & r_we & ~r_blocked;
    bus.addr_bus     = r_addr;
    bus.Cpu_data2bus = r_wdata;
    bus.m0_ack       = (r_state == StAck) & ~r_owner;
    bus.m1_ack       = (r_state == StAck) & r_owner;
    bus.m0_err       = 1'b0;
    bus.m1_err       = (r_state == StAck) & r_owner & r_blocked;
    bus.m0_rdata     = r_rdata0;
    bus.m1_rdata     = r_rdata1;
    bus.bus_busy     = (r_state != StIdle);
    bus.grant        = r_owner;
  end

endmodule
